irq_pending_controller: RTL and testbench

IRQ_PENDING_CONTROLLER -- requirements
Module: irq_pending_controller

---
 rtl/irq_pending_controller.sv | 112 +++++++++++
 tb/tb_irq_pending_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_controller.sv
// irq_pending_controller
//
// Latches rising edges on four level request lines into a pending vector,
// then presents the highest-priority unmasked pending request to a consumer
// as an (irq_valid, irq_id) pair. The presented id is held until the
// consumer acknowledges it. The acknowledge clears that pending bit.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     asynchronous active-low reset
//   req_in    level request lines; bit 3 has the highest priority
//   mask      per-line mask; a masked line is still latched but never selected
//   irq_ack   consumer acknowledge for the presented id
//   irq_valid a selected request is being presented
//   irq_id    encoded index of the presented request
//   pending   registered pending-request vector
//   ovf       one-cycle pulse when a request edge is lost on an already-pending line
module irq_pending_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       irq_ack,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic       ovf
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state;
    logic [3:0] req_d;
    logic [3:0] req_edge;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [1:0] sel_id;

    assign req_edge = req_in & ~req_d;
    assign eligible = pending & ~mask;

    // Only an acknowledge of a request that is being presented clears a bit.
    // An acknowledge while idle is therefore ignored.
    always_comb begin
        clr = 4'b0000;
        if (state == PRESENT && irq_ack) begin
            clr[irq_id] = 1'b1;
        end
    end

    // Fixed-priority select: the highest set bit wins.
    always_comb begin
        sel_id = 2'd0;
        if (eligible[3]) begin
            sel_id = 2'd3;
        end else if (eligible[2]) begin
            sel_id = 2'd2;
        end else if (eligible[1]) begin
            sel_id = 2'd1;
        end else begin
            sel_id = 2'd0;
        end
    end

    // A new edge wins over a same-cycle clear. The new edge counts as lost only
    // if the bit is already pending and is not being cleared in this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d   <= 4'b0000;
            pending <= 4'b0000;
            ovf     <= 1'b0;
        end else begin
            req_d   <= req_in;
            pending <= (pending & ~clr) | req_edge;
            ovf     <= |(req_edge & pending & ~clr);
        end
    end

    // The id is captured once on grant and then frozen until acknowledge.
    // Later arrivals or mask changes therefore cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != 4'b0000) begin
                        irq_id    <= sel_id;
                        irq_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        irq_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    irq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_controller.sv
// tb_irq_pending_controller
//
// Directed testbench for irq_pending_controller. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at the same point. Each
// expected value was worked out by hand from the required behaviour.
module tb_irq_pending_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       ovf;

    int checks;
    int failures;

    irq_pending_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] m, input logic a);
        req_in  = r;
        mask    = m;
        irq_ack = a;
    endtask

    task automatic check_output(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Checks every output in one call.
    task automatic check_all(input string tag, input logic [3:0] exp_pend, input logic exp_valid,
                             input logic [1:0] exp_id, input logic exp_ovf);
        check_output({tag, ".pending"}, pending, exp_pend);
        check_output({tag, ".valid"}, {3'b0, irq_valid}, {3'b0, exp_valid});
        check_output({tag, ".id"}, {2'b0, irq_id}, {2'b0, exp_id});
        check_output({tag, ".ovf"}, {3'b0, ovf}, {3'b0, exp_ovf});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        #3;
        check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_all("post_reset_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Single request
        $display("[TB] single request");
        apply_stimulus(4'b0100, 4'b0000, 1'b0);
        tick();
        check_all("single.e1", 4'b0100, 1'b0, 2'd0, 1'b0);
        tick();
        check_all("single.e2", 4'b0100, 1'b1, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("single.ack", 4'b0000, 1'b0, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);

        // Priority order 3, 1, 0
        $display("[TB] priority");
        apply_stimulus(4'b1011, 4'b0000, 1'b0);
        tick();
        check_all("prio.latch", 4'b1011, 1'b0, 2'd2, 1'b0);
        tick();
        check_all("prio.g3", 4'b1011, 1'b1, 2'd3, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("prio.ack3", 4'b0011, 1'b0, 2'd3, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("prio.g1", 4'b0011, 1'b1, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("prio.ack1", 4'b0001, 1'b0, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("prio.g0", 4'b0001, 1'b1, 2'd0, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("prio.ack0", 4'b0000, 1'b0, 2'd0, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);

        // Presented id held against a higher-priority arrival
        $display("[TB] hold");
        apply_stimulus(4'b0010, 4'b0000, 1'b0);
        tick();
        check_all("hold.latch", 4'b0010, 1'b0, 2'd0, 1'b0);
        tick();
        check_all("hold.g1", 4'b0010, 1'b1, 2'd1, 1'b0);
        apply_stimulus(4'b1010, 4'b0000, 1'b0);
        tick();
        check_all("hold.arrive3", 4'b1010, 1'b1, 2'd1, 1'b0);
        tick();
        check_all("hold.still1", 4'b1010, 1'b1, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("hold.ack1", 4'b1000, 1'b0, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("hold.g3", 4'b1000, 1'b1, 2'd3, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("hold.ack3", 4'b0000, 1'b0, 2'd3, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);

        // Mask excludes bit 2 from selection but still latches it
        $display("[TB] mask");
        apply_stimulus(4'b0110, 4'b0100, 1'b0);
        tick();
        check_all("mask.latch", 4'b0110, 1'b0, 2'd3, 1'b0);
        tick();
        check_all("mask.g1", 4'b0110, 1'b1, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("mask.ack1", 4'b0100, 1'b0, 2'd1, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("mask.g2", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Overflow: re-pulse bit 2 while it is still pending and presented
        $display("[TB] overflow");
        apply_stimulus(4'b0100, 4'b0000, 1'b0);
        tick();
        check_all("ovf.pulse", 4'b0100, 1'b1, 2'd2, 1'b1);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("ovf.drop", 4'b0100, 1'b1, 2'd2, 1'b0);
        // Same-cycle edge and acknowledge: the set wins and no overflow occurs
        apply_stimulus(4'b0100, 4'b0000, 1'b1);
        tick();
        check_all("setclr.win", 4'b0100, 1'b0, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("setclr.regrant", 4'b0100, 1'b1, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("setclr.ack", 4'b0000, 1'b0, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);

        // Acknowledge while idle changes nothing. With eligible empty, the id is kept.
        $display("[TB] idle ack");
        apply_stimulus(4'b0001, 4'b0001, 1'b0);
        tick();
        check_all("idle.latch", 4'b0001, 1'b0, 2'd2, 1'b0);
        tick();
        check_all("idle.masked", 4'b0001, 1'b0, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0001, 1'b1);
        tick();
        check_all("idle.ack_ignored", 4'b0001, 1'b0, 2'd2, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("idle.g0", 4'b0001, 1'b1, 2'd0, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        check_all("idle.ack0", 4'b0000, 1'b0, 2'd0, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 1'b0);

        // Asynchronous reset mid-presentation, then a held line re-edges after release
        $display("[TB] reset mid-operation");
        apply_stimulus(4'b1010, 4'b0000, 1'b0);
        tick();
        tick();
        check_all("rst.before", 4'b1010, 1'b1, 2'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst.async", 4'b0000, 1'b0, 2'd0, 1'b0);
        apply_stimulus(4'b1000, 4'b0000, 1'b0);
        tick();
        check_all("rst.held", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("rst.reedge", 4'b1000, 1'b0, 2'd0, 1'b0);
        tick();
        check_all("rst.grant", 4'b1000, 1'b1, 2'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
